// File: rtl/intt_halving_sched.sv
// ============================================================================
// intt_halving_sched : streams a coefficient bank through a mod-q divide-by-2
//                      unit in place, repeated npass times (2^-k scaling).
// Rev 1.0
// ============================================================================
`default_nettype none

module intt_halving_sched #(
  parameter int LOGQ       = 64,
  parameter int LOGN       = 8,
  parameter int PASS_W     = 6,
  parameter int DELAY_BRAM = 2,
  parameter int DELAY_DIV2 = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PASS_W-1:0] npass,
  input  logic [LOGQ-1:0]   q,
  output logic              rd_en,
  output logic [LOGN-1:0]   rd_addr,
  input  logic [LOGQ-1:0]   rd_data,
  output logic [LOGQ-1:0]   div_x,
  output logic [LOGQ-1:0]   div_q,
  output logic              div_intt,
  input  logic [LOGQ-1:0]   div_y,
  output logic              wr_en,
  output logic [LOGN-1:0]   wr_addr,
  output logic [LOGQ-1:0]   wr_data,
  output logic              busy,
  output logic              done
);

  localparam int              c_L         = DELAY_BRAM + DELAY_DIV2;
  localparam logic [LOGN-1:0] c_ADDR_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t              state_q;
  logic [LOGN-1:0]     raddr_q;
  logic [PASS_W-1:0]   pass_q;
  logic [PASS_W-1:0]   npass_q;
  logic [LOGQ-1:0]     qmod_q;
  logic                rd_en_q;
  logic                busy_q;
  logic                done_q;
  logic [c_L-1:0]      vld_q;
  logic [LOGN-1:0]     addr_q [c_L];

  logic [PASS_W-1:0]   pass_d;
  logic                w_wr_last;

  assign pass_d    = pass_q + 1'b1;
  assign w_wr_last = vld_q[c_L-1] && (addr_q[c_L-1] == c_ADDR_LAST);

  // Read valid and address travel together so each write lands on the address it was read from.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < c_L; i++) addr_q[i] <= '0;
    end else begin
      vld_q[0]  <= rd_en_q;
      addr_q[0] <= raddr_q;
      for (int i = 1; i < c_L; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      raddr_q <= '0;
      pass_q  <= '0;
      npass_q <= '0;
      qmod_q  <= '0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            npass_q <= npass;
            qmod_q  <= q;
            pass_q  <= '0;
            raddr_q <= '0;
            if (npass == '0) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_READ;
              rd_en_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        S_READ: begin
          // Address wraps to 0 after N-1, ready for the next pass.
          raddr_q <= raddr_q + 1'b1;
          if (raddr_q == c_ADDR_LAST) begin
            rd_en_q <= 1'b0;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_wr_last) begin
            pass_q <= pass_d;
            if (pass_d < npass_q) begin
              state_q <= S_READ;
              rd_en_q <= 1'b1;
            end else begin
              state_q <= S_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_en    = rd_en_q;
  assign rd_addr  = raddr_q;
  assign div_x    = rd_data;
  assign div_q    = qmod_q;
  assign div_intt = vld_q[DELAY_BRAM-1];
  assign wr_en    = vld_q[c_L-1];
  assign wr_addr  = addr_q[c_L-1];
  assign wr_data  = div_y;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_intt_halving_sched.sv
// ============================================================================
// tb_intt_halving_sched : directed bench with a cycle-schedule model and a
//                         memory / divide-by-2 environment.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_intt_halving_sched;

  localparam int LOGQ = 64;
  localparam int LOGN = 3;
  localparam int PASS_W = 6;
  localparam int DB = 1;
  localparam int DD = 1;
  localparam int N = 1 << LOGN;
  localparam int L = DB + DD;
  localparam int P = N + L;

  logic              clk = 1'b0;
  logic              rst, start;
  logic [PASS_W-1:0] npass;
  logic [LOGQ-1:0]   q;
  logic              rd_en, div_intt, wr_en, busy, done;
  logic [LOGN-1:0]   rd_addr, wr_addr;
  logic [LOGQ-1:0]   rd_data, div_x, div_q, div_y, wr_data;

  intt_halving_sched #(.LOGQ(LOGQ), .LOGN(LOGN), .PASS_W(PASS_W),
                       .DELAY_BRAM(DB), .DELAY_DIV2(DD)) dut (
    .clk(clk), .rst(rst), .start(start), .npass(npass), .q(q),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .div_x(div_x), .div_q(div_q), .div_intt(div_intt), .div_y(div_y),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] half(input logic [63:0] x, input logic [63:0] m);
    if (!x[0]) return x >> 1;
    return (x >> 1) + (m >> 1) + 64'd1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask

  // Environment: BRAM (1-cycle read) and the divide-by-2 unit (1-cycle).
  logic [63:0] mem [N];
  logic [63:0] img [N];
  logic        ld = 1'b0;
  logic [63:0] rdat = '0;
  logic [63:0] dy = '0;
  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < N; i++) mem[i] <= img[i];
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) rdat <= mem[rd_addr];
    dy <= div_intt ? half(div_x, div_q) : div_x;
  end
  assign rd_data = rdat;
  assign div_y   = dy;

  // Schedule model: every output derived from the cycle offset since start.
  bit          chk_en = 0;
  bit          act = 0;
  int          t0 = 0;
  int          mk = 0;
  logic [63:0] qm = '0;
  int          wr_cnt = 0, rd_cnt = 0, dn_cnt = 0, done_rel = -1;

  always @(negedge clk) begin
    int r, kp, off;
    bit e_rd, e_wr, e_di, e_busy, e_done;
    int e_ra, e_wa;
    r = cyc - t0;
    kp = mk * P;
    e_rd = 0; e_wr = 0; e_di = 0; e_busy = 0; e_ra = 0; e_wa = 0;
    e_done = act && (r == kp + 1);
    if (act && r >= 1 && r <= kp) begin
      off = (r - 1) % P;
      e_busy = 1;
      e_rd = off < N;
      e_ra = off;
      e_wr = (off >= L) && (off < N + L);
      e_wa = off - L;
      e_di = (off >= DB) && (off < N + DB);
    end
    if (chk_en) begin
      chk("rd_en", 64'(rd_en), 64'(e_rd));
      if (e_rd) chk("rd_addr", 64'(rd_addr), 64'(e_ra));
      chk("wr_en", 64'(wr_en), 64'(e_wr));
      if (e_wr) chk("wr_addr", 64'(wr_addr), 64'(e_wa));
      chk("div_intt", 64'(div_intt), 64'(e_di));
      if (e_di) begin
        chk("div_q", div_q, qm);
        chk("div_x", div_x, rd_data);
      end
      chk("busy", 64'(busy), 64'(e_busy));
      chk("done", 64'(done), 64'(e_done));
      if (wr_en) wr_cnt++;
      if (rd_en) rd_cnt++;
      if (done) begin
        dn_cnt++;
        done_rel = r;
      end
    end
    if (rst) begin
      act = 0;
    end else if (start && (!act || r >= kp + 2)) begin
      act = 1; t0 = cyc; mk = int'(npass); qm = q;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_img();
    ld = 1'b1;
    tick();
    ld = 1'b0;
  endtask

  task automatic begin_run(input int k, input logic [63:0] qv);
    wr_cnt = 0; rd_cnt = 0; dn_cnt = 0; done_rel = -1;
    start = 1'b1; npass = PASS_W'(k); q = qv;
    tick();
    start = 1'b0;
  endtask

  task automatic check_mem(input string nm, input int k, input logic [63:0] qv);
    logic [63:0] v;
    for (int i = 0; i < N; i++) begin
      v = img[i];
      for (int j = 0; j < k; j++) v = half(v, qv);
      chk(nm, mem[i], v);
    end
  endtask

  logic [63:0] exp2 [N] = '{64'd0, 64'd9, 64'd1, 64'd10, 64'd2, 64'd11, 64'd3, 64'd12};
  localparam logic [63:0] QBIG = 64'hFFFF_FFFF_FFFF_FFC5;

  initial begin
    rst = 1'b1; start = 1'b0; npass = '0; q = '0;
    for (int i = 0; i < N; i++) img[i] = 64'd5;
    tick(); tick();
    chk_en = 1;
    load_img();
    rst = 1'b0;
    tick();

    // All 5, q=17, k=3: 5 -> 11 -> 14 -> 7
    begin_run(3, 64'd17);
    repeat (3 * P + 4) tick();
    chk("t1_done_cycle", 64'(done_rel), 64'd31);
    chk("t1_writes", 64'(wr_cnt), 64'd24);
    for (int i = 0; i < N; i++) chk("t1_mem_lit", mem[i], 64'd7);
    check_mem("t1_mem", 3, 64'd17);

    // Ramp 0..7, k=1
    for (int i = 0; i < N; i++) img[i] = 64'(i);
    load_img();
    begin_run(1, 64'd17);
    repeat (P + 4) tick();
    chk("t2_done_cycle", 64'(done_rel), 64'd11);
    chk("t2_writes", 64'(wr_cnt), 64'd8);
    for (int i = 0; i < N; i++) chk("t2_mem_lit", mem[i], exp2[i]);

    // npass = 0: immediate done, no memory traffic
    load_img();
    begin_run(0, 64'd17);
    repeat (4) tick();
    chk("t3_done_cycle", 64'(done_rel), 64'd1);
    chk("t3_writes", 64'(wr_cnt), 64'd0);
    chk("t3_reads", 64'(rd_cnt), 64'd0);
    check_mem("t3_mem", 0, 64'd17);

    // Re-pulsed start while busy is ignored
    load_img();
    begin_run(1, 64'd17);
    repeat (4) tick();
    start = 1'b1; npass = 6'd3;
    tick();
    start = 1'b0;
    repeat (P + 2) tick();
    chk("t4_done_cycle", 64'(done_rel), 64'd11);
    chk("t4_done_count", 64'(dn_cnt), 64'd1);
    for (int i = 0; i < N; i++) chk("t4_mem_lit", mem[i], exp2[i]);

    // Reset during a two-pass run, then a clean single pass
    load_img();
    begin_run(2, 64'd17);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("t5_writes_before_rst", 64'(wr_cnt), 64'd4);
    load_img();
    begin_run(1, 64'd17);
    repeat (P + 4) tick();
    chk("t5_done_cycle", 64'(done_rel), 64'd11);
    chk("t5_writes", 64'(wr_cnt), 64'd8);
    check_mem("t5_mem", 1, 64'd17);

    // Full-width modulus, x = q-1
    for (int i = 0; i < N; i++) img[i] = QBIG - 64'd1;
    load_img();
    begin_run(1, QBIG);
    repeat (P + 4) tick();
    for (int i = 0; i < N; i++) chk("t6_mem_lit", mem[i], 64'h7FFF_FFFF_FFFF_FFE2);
    check_mem("t6_mem", 1, QBIG);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/intt_halving_sched.md
Name: intt_halving_sched

Overview:
- Sequencer that applies k-fold modular halving (multiply by 2^-k mod q) in place to an N-coefficient polynomial bank.
- Used for the final INTT scaling step when N^-1 is applied as repeated divide-by-2 instead of a constant multiply.
- Streams coefficients out of a BRAM read port, through the existing modular divide-by-2 unit, and back to the same addresses through a write port.
- Repeats for a programmed number of passes; one coefficient per cycle.

Parameters:
- LOGQ, 64: coefficient/modulus width.
- LOGN, 8: log2 of polynomial length; N = 2^LOGN.
- PASS_W, 6: width of the pass-count input.
- DELAY_BRAM, 2: read latency, from rd_en to valid rd_data.
- DELAY_DIV2, 1: latency of the divide-by-2 unit, from div_x to div_y.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin; ignored while busy=1.
- npass  in  PASS_W  number of halving passes k; sampled when start is accepted.
- q  in  LOGQ  modulus (odd); sampled when start is accepted.
- rd_en  out  1  BRAM read enable.
- rd_addr  out  LOGN  BRAM read address.
- rd_data  in  LOGQ  BRAM read data; valid DELAY_BRAM cycles after rd_en.
- div_x  out  LOGQ  operand to the divide-by-2 unit; equals rd_data.
- div_q  out  LOGQ  modulus to the divide-by-2 unit; the latched q.
- div_intt  out  1  divide enable; 1 while a valid operand is presented, else 0.
- div_y  in  LOGQ  divide-by-2 result; valid DELAY_DIV2 cycles after div_x.
- wr_en  out  1  BRAM write enable.
- wr_addr  out  LOGN  BRAM write address.
- wr_data  out  LOGQ  BRAM write data; equals div_y.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Define L = DELAY_BRAM + DELAY_DIV2.
- Reset: state IDLE. rd_en, wr_en, div_intt, busy and done are all 0. Addresses, the pass counter, latched q/npass and the valid/address delay pipe are all cleared.
- Reset mid-operation: in-flight writes are dropped. No wr_en is asserted after rst is sampled high.
- States:
  - IDLE: on start, latch npass and q. If npass=0, go to FIN. Otherwise go to READ with pass=0 and raddr=0.
  - READ: assert rd_en with rd_addr=raddr; raddr increments. After issuing address N-1, go to DRAIN.
  - DRAIN: no reads. Wait until the write of address N-1 for this pass has been issued. Then pass increments. If pass < npass, go to READ with raddr=0; otherwise go to FIN.
  - FIN: done=1 for one cycle, busy=0, return to IDLE.
- Timing:
  - start is sampled at cycle 0; the first rd_en is at cycle 1.
  - A read issued at cycle c produces wr_en at cycle c+L, with wr_addr equal to that read's address.
  - wr_addr is carried by an L-deep address/valid shift pipe.
  - The next pass's first read is at the cycle after the previous pass's last write. This strictly orders write-after-read, so there is no RAW hazard.
  - Pass p (1-based) makes its last write at cycle p*(N+L).
  - done is high at cycle k*(N+L)+1; busy is high on cycles 1..k*(N+L).
  - npass=0: done is high at cycle 1, busy never rises, and there is no memory access.
- div_intt mirrors the delayed-read valid (rd_en delayed DELAY_BRAM). The divider therefore passes data through unchanged when div_intt=0.
- start during busy or FIN has no effect and is not queued. start in the same cycle as rst is ignored.
- Exactly N wr_en pulses per pass and N*k in total. Addresses are 0..N-1 in order with no gaps or repeats.

Test Plan:
- LOGN=3, q=17, DELAY_BRAM=1, DELAY_DIV2=1 (L=2); memory all 5, npass=3 → every word becomes 7 (5→11→14→7). done pulses at cycle 31. 24 writes total.
- Same config, memory = 0..7, npass=1 → result 0,9,1,10,2,11,3,12. wr_addr sequence is 0..7 at cycles 3..10. done at cycle 11.
- npass=0 with start → done at cycle 1, no rd_en/wr_en, memory unchanged, busy stays 0.
- start re-pulsed at cycle 5 while busy (npass=1) → ignored; single done at cycle 11; memory halved once only.
- rst asserted at cycle 6 of a npass=2 run → from the next cycle rd_en=wr_en=busy=done=0. A subsequent start with npass=1 completes normally, with done at cycle 11 relative to that start.
- LOGQ=64, q=2^64-59, memory word x=q-1, npass=1 → result (q-1)/2; no carry overflow.
